// File: rtl/execute_y_mulpipe_if.sv
// execute_y_mulpipe_if
//   Issue, flush, writeback and hazard signals of the Y-lane multiply unit.
//   slave  : the execute unit (consumes issue/flush/wb_ready, drives results)
//   master : issue stage / writeback side (drives issue/flush/wb_ready)
// Optional feature macro: EXEC_Y_SIGNED_EN adds is_y_signed.
//
// Signals
//   is_y_functionalunit [1:0]        unit code, matched against UNIT_ID
//   is_y_rega / is_y_regb [DATA_W]   multiplicand / multiplier
//   is_y_regdest [REG_W]             destination register
//   is_y_hi                          1 = high product half, 0 = low half
//   is_y_signed                      signed operands (EXEC_Y_SIGNED_EN only)
//   y_flush                          kill every in-flight op
//   wb_y_ready                       writeback takes the current result
//   y_is_ready                       unit can take an issue this cycle
//   y_is_busy [2**REG_W]             per-register in-flight mask
//   y_wb_regdest / y_wb_writereg / y_wb_wbvalue   writeback result
interface execute_y_mulpipe_if #(
  parameter int DATA_W = 32,
  parameter int REG_W  = 5
);
  logic [1:0]          is_y_functionalunit;
  logic [DATA_W-1:0]   is_y_rega;
  logic [DATA_W-1:0]   is_y_regb;
  logic [REG_W-1:0]    is_y_regdest;
  logic                is_y_hi;
`ifdef EXEC_Y_SIGNED_EN
  logic                is_y_signed;
`endif
  logic                y_flush;
  logic                wb_y_ready;
  logic                y_is_ready;
  logic [2**REG_W-1:0] y_is_busy;
  logic [REG_W-1:0]    y_wb_regdest;
  logic                y_wb_writereg;
  logic [DATA_W-1:0]   y_wb_wbvalue;

  modport slave (
    input  is_y_functionalunit, is_y_rega, is_y_regb, is_y_regdest, is_y_hi,
`ifdef EXEC_Y_SIGNED_EN
    input  is_y_signed,
`endif
    input  y_flush, wb_y_ready,
    output y_is_ready, y_is_busy, y_wb_regdest, y_wb_writereg, y_wb_wbvalue
  );

  modport master (
    output is_y_functionalunit, is_y_rega, is_y_regb, is_y_regdest, is_y_hi,
`ifdef EXEC_Y_SIGNED_EN
    output is_y_signed,
`endif
    output y_flush, wb_y_ready,
    input  y_is_ready, y_is_busy, y_wb_regdest, y_wb_writereg, y_wb_wbvalue
  );
endinterface

// File: rtl/execute_y_mulpipe.sv
// execute_y_mulpipe
//   Y-lane multiply execute unit. LATENCY register stages S1..SL: S1 holds the
//   operands, S2 receives the full 2*DATA_W product, middle stages delay it,
//   and the selected half is taken on entry to SL, which drives writeback.
//   Writeback back-pressure stalls the whole pipe (bubbles are kept, so
//   results retire in issue order). Flush clears every valid bit.
// Optional feature macro: EXEC_Y_SIGNED_EN (signed multiply via is_y_signed).
//
// Ports
//   clock  : rising-edge clock
//   reset  : asynchronous active-low reset
//   y_bus  : execute_y_mulpipe_if.slave (issue, flush, writeback, busy mask)
// Parameters
//   DATA_W, REG_W, LATENCY (2..8), UNIT_ID
module execute_y_mulpipe #(
  parameter int DATA_W  = 32,
  parameter int REG_W   = 5,
  parameter int LATENCY = 4,
  parameter int UNIT_ID = 3
) (
  input logic                clock,
  input logic                reset,
  execute_y_mulpipe_if.slave y_bus
);

  localparam int         PW        = 2 * DATA_W;
  localparam int         NREG      = 2 ** REG_W;
  localparam logic [1:0] UNIT_CODE = 2'(UNIT_ID);

  logic [LATENCY-1:0] vld;
  logic [REG_W-1:0]   dst [LATENCY];
  logic [LATENCY-2:0] hi_q;          // SL itself no longer needs the half select
  logic [DATA_W-1:0]  s1_a;
  logic [DATA_W-1:0]  s1_b;
  logic [DATA_W-1:0]  sl_data;
  logic [PW-1:0]      ext_a;
  logic [PW-1:0]      ext_b;
  logic [PW-1:0]      prod_c;
  logic [PW-1:0]      sl_full;       // full product of the stage feeding SL
  logic [NREG-1:0]    busy;
  logic               stall;
  logic               accept;

  assign stall  = vld[LATENCY-1] & ~y_bus.wb_y_ready;
  assign accept = (y_bus.is_y_functionalunit == UNIT_CODE) & ~stall & ~y_bus.y_flush;

  // Dest 0 ops are taken but never become valid: no writeback, no busy bit.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      vld <= '0;
    end else if (y_bus.y_flush) begin
      vld <= '0;
    end else if (!stall) begin
      vld <= {vld[LATENCY-2:0], accept & (y_bus.is_y_regdest != '0)};
    end
  end

  // Data/control registers advance on every unstalled edge; valid bits gate use.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < LATENCY; i++) dst[i] <= '0;
      hi_q <= '0;
      s1_a <= '0;
      s1_b <= '0;
    end else if (!stall) begin
      dst[0]  <= y_bus.is_y_regdest;
      for (int i = 1; i < LATENCY; i++) dst[i] <= dst[i-1];
      hi_q[0] <= y_bus.is_y_hi;
      for (int i = 1; i < LATENCY - 1; i++) hi_q[i] <= hi_q[i-1];
      s1_a    <= y_bus.is_y_rega;
      s1_b    <= y_bus.is_y_regb;
    end
  end

`ifdef EXEC_Y_SIGNED_EN
  // The signed flag is only needed until the product is formed out of S1.
  logic s1_sgn;
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      s1_sgn <= 1'b0;
    end else if (!stall) begin
      s1_sgn <= y_bus.is_y_signed;
    end
  end
`endif

  // Extending to full width and keeping the low 2*DATA_W bits of the product
  // yields the correct signed or unsigned double-width result.
  always_comb begin
    ext_a = {{DATA_W{1'b0}}, s1_a};
    ext_b = {{DATA_W{1'b0}}, s1_b};
`ifdef EXEC_Y_SIGNED_EN
    if (s1_sgn) begin
      ext_a = {{DATA_W{s1_a[DATA_W-1]}}, s1_a};
      ext_b = {{DATA_W{s1_b[DATA_W-1]}}, s1_b};
    end
`endif
  end

  assign prod_c = ext_a * ext_b;

  generate
    if (LATENCY == 2) begin : g_short
      // S2 is SL: the product is truncated straight out of S1.
      assign sl_full = prod_c;
    end else begin : g_long
      logic [PW-1:0] pp_q [LATENCY-2];   // full product in S2..S(L-1)
      always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
          for (int i = 0; i < LATENCY - 2; i++) pp_q[i] <= '0;
        end else if (!stall) begin
          pp_q[0] <= prod_c;
          for (int i = 1; i < LATENCY - 2; i++) pp_q[i] <= pp_q[i-1];
        end
      end
      assign sl_full = pp_q[LATENCY-3];
    end
  endgenerate

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sl_data <= '0;
    end else if (!stall) begin
      sl_data <= hi_q[LATENCY-2] ? sl_full[PW-1:DATA_W] : sl_full[DATA_W-1:0];
    end
  end

  always_comb begin
    busy = '0;
    for (int i = 0; i < LATENCY; i++) begin
      if (vld[i]) busy[dst[i]] = 1'b1;
    end
  end

  assign y_bus.y_is_ready    = ~stall;
  assign y_bus.y_is_busy     = busy;
  assign y_bus.y_wb_regdest  = dst[LATENCY-1];
  assign y_bus.y_wb_writereg = vld[LATENCY-1];
  assign y_bus.y_wb_wbvalue  = sl_data;

endmodule

// File: tb/tb_execute_y_mulpipe.sv
// tb_execute_y_mulpipe
//   Scoreboard bench for execute_y_mulpipe at default parameters. Issues push
//   {dest, value, retire cycle} into a queue; a negedge monitor compares every
//   presented writeback against the queue head and pops on acceptance.
module tb_execute_y_mulpipe;

  typedef struct {
    logic [4:0]  dest;
    logic [31:0] value;
    int          cyc;
  } req_t;

  logic clk;
  logic rst_n;
  int   cyc   = 0;
  int   total = 0;
  int   bad   = 0;
  req_t req_q[$];

  execute_y_mulpipe_if #(.DATA_W(32), .REG_W(5)) bus();

  execute_y_mulpipe dut (
    .clock (clk),
    .reset (rst_n),
    .y_bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=0x%0h required=0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [1:0] fu, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] d, input logic hi, input logic sg);
    bus.is_y_functionalunit = fu;
    bus.is_y_rega           = a;
    bus.is_y_regb           = b;
    bus.is_y_regdest        = d;
    bus.is_y_hi             = hi;
`ifdef EXEC_Y_SIGNED_EN
    bus.is_y_signed         = sg;
`else
    if (sg) $display("note: signed request ignored in unsigned build");
`endif
  endtask

  task automatic idle();
    bus.is_y_functionalunit = 2'd0;
  endtask

  // Issue an accepted op in the current cycle; ret is the expected retire offset.
  task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic [4:0] d,
                       input logic hi, input logic sg, input logic [31:0] v, input int ret);
    drive(2'd3, a, b, d, hi, sg);
    req_q.push_back('{dest: d, value: v, cyc: cyc + ret});
    next();
  endtask

  // Monitor: decoupled from stimulus; every presented result is checked.
  always @(negedge clk) begin
    if (rst_n && bus.y_wb_writereg) begin
      if (req_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_wb actual dest=%0d value=0x%0h required=none (cycle %0d)",
                 bus.y_wb_regdest, bus.y_wb_wbvalue, cyc);
      end else begin
        chk("wb_dest", 64'(bus.y_wb_regdest), 64'(req_q[0].dest));
        chk("wb_value", 64'(bus.y_wb_wbvalue), 64'(req_q[0].value));
        if (bus.wb_y_ready) begin
          chk("wb_cycle", 64'(cyc), 64'(req_q[0].cyc));
          void'(req_q.pop_front());
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n          = 1'b0;
    bus.wb_y_ready = 1'b1;
    bus.y_flush    = 1'b0;
    drive(2'd0, 32'd0, 32'd0, 5'd0, 1'b0, 1'b0);
    repeat (2) next();
    chk("rst_writereg", 64'(bus.y_wb_writereg), 64'd0);
    chk("rst_regdest", 64'(bus.y_wb_regdest), 64'd0);
    chk("rst_wbvalue", 64'(bus.y_wb_wbvalue), 64'd0);
    chk("rst_busy", 64'(bus.y_is_busy), 64'd0);
    rst_n = 1'b1;
    next();
    chk("post_rst_ready", 64'(bus.y_is_ready), 64'd1);

    // Basic latency and busy window: 7 x 6 -> 42 to r3.
    chk("busy_before", 64'(bus.y_is_busy), 64'd0);
    issue(32'd7, 32'd6, 5'd3, 1'b0, 1'b0, 32'd42, 4);
    for (int k = 1; k <= 4; k++) begin
      if (k == 1) idle();
      chk("busy_r3", 64'(bus.y_is_busy), 64'h8);
      next();
    end
    chk("busy_r3_clear", 64'(bus.y_is_busy), 64'd0);

    // Product halves, back to back.
    issue(32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd5, 1'b1, 1'b0, 32'hFFFF_FFFE, 4);
    issue(32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd6, 1'b0, 1'b0, 32'h0000_0001, 4);
    issue(32'h0001_0000, 32'h0001_0000, 5'd7, 1'b1, 1'b0, 32'h0000_0001, 4);
    issue(32'h0001_0000, 32'h0001_0000, 5'd8, 1'b0, 1'b0, 32'h0000_0000, 4);
`ifdef EXEC_Y_SIGNED_EN
    issue(32'hFFFF_FFFE, 32'd3, 5'd9, 1'b1, 1'b1, 32'hFFFF_FFFF, 4);
    issue(32'hFFFF_FFFE, 32'd3, 5'd10, 1'b0, 1'b1, 32'hFFFF_FFFA, 4);
    issue(32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd11, 1'b1, 1'b1, 32'h0000_0000, 4);
    issue(32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd12, 1'b0, 1'b1, 32'h0000_0001, 4);
`else
    issue(32'hFFFF_FFFE, 32'd3, 5'd9, 1'b1, 1'b0, 32'h0000_0002, 4);
    issue(32'hFFFF_FFFE, 32'd3, 5'd10, 1'b0, 1'b0, 32'hFFFF_FFFA, 4);
`endif
    idle();
    repeat (6) next();

    // Back-pressure: four ops, writeback stalled two cycles on the first.
    issue(32'd2, 32'd10, 5'd1, 1'b0, 1'b0, 32'd20, 6);
    issue(32'd3, 32'd10, 5'd2, 1'b0, 1'b0, 32'd30, 6);
    issue(32'd4, 32'd10, 5'd3, 1'b0, 1'b0, 32'd40, 6);
    issue(32'd5, 32'd10, 5'd4, 1'b0, 1'b0, 32'd50, 6);
    idle();
    bus.wb_y_ready = 1'b0;
    #1;
    chk("stall_writereg", 64'(bus.y_wb_writereg), 64'd1);
    chk("stall_ready0", 64'(bus.y_is_ready), 64'd0);
    chk("stall_busy", 64'(bus.y_is_busy), 64'h1E);
    next();
    chk("stall_ready1", 64'(bus.y_is_ready), 64'd0);
    next();
    bus.wb_y_ready = 1'b1;
    #1;
    chk("release_ready", 64'(bus.y_is_ready), 64'd1);
    repeat (6) next();

    // Flush together with an issue.
    issue(32'd3, 32'd3, 5'd7, 1'b0, 1'b0, 32'd9, 4);
    issue(32'd4, 32'd4, 5'd8, 1'b0, 1'b0, 32'd16, 4);
    void'(req_q.pop_back());
    void'(req_q.pop_back());
    drive(2'd3, 32'd5, 32'd5, 5'd9, 1'b0, 1'b0);
    bus.y_flush = 1'b1;
    #1;
    chk("flush_ready", 64'(bus.y_is_ready), 64'd1);
    chk("flush_busy_before", 64'(bus.y_is_busy), 64'h180);
    next();
    bus.y_flush = 1'b0;
    idle();
    chk("flush_busy_after", 64'(bus.y_is_busy), 64'd0);
    repeat (6) next();

    // Async reset with two ops in flight, then a fresh op.
    drive(2'd3, 32'd5, 32'd5, 5'd10, 1'b0, 1'b0);
    next();
    drive(2'd3, 32'd6, 32'd6, 5'd11, 1'b0, 1'b0);
    next();
    idle();
    chk("pre_rst_busy", 64'(bus.y_is_busy), 64'hC00);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", 64'(bus.y_is_busy), 64'd0);
    chk("mid_rst_writereg", 64'(bus.y_wb_writereg), 64'd0);
    chk("mid_rst_regdest", 64'(bus.y_wb_regdest), 64'd0);
    chk("mid_rst_wbvalue", 64'(bus.y_wb_wbvalue), 64'd0);
    next();
    rst_n = 1'b1;
    next();
    chk("rerun_ready", 64'(bus.y_is_ready), 64'd1);
    issue(32'd9, 32'd9, 5'd12, 1'b0, 1'b0, 32'd81, 4);
    idle();
    repeat (6) next();

    // Other unit code, and dest 0: neither writes back nor sets busy.
    drive(2'd1, 32'd4, 32'd4, 5'd4, 1'b0, 1'b0);
    next();
    chk("other_unit_busy", 64'(bus.y_is_busy), 64'd0);
    drive(2'd3, 32'd4, 32'd4, 5'd0, 1'b0, 1'b0);
    #1;
    chk("dest0_ready", 64'(bus.y_is_ready), 64'd1);
    next();
    idle();
    chk("dest0_busy", 64'(bus.y_is_busy), 64'd0);
    repeat (6) next();
    chk("idle_ready", 64'(bus.y_is_ready), 64'd1);

    for (int i = 0; i < 30 && req_q.size() != 0; i++) next();
    chk("drain_empty", 64'(req_q.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
